// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the single write port of an 8-bit sync FIFO
// among NUM_REQ producers, granting bursts of up to BURST beats. Define ARB_STALL_CNT_EN to add stall_cnt.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int BURST   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // Handshake: req[i] is the valid, gnt[i] is the accept. A beat transfers on every
  // cycle gnt[i]=1; req[i] and its req_data slice must stay stable until that cycle.
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next;

  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             sel_vld;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Cyclic priority scan: first set request at or after rr_ptr.
  always_comb begin
    sel_idx  = rr_ptr;
    sel_vld  = 1'b0;
    scan_idx = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_vld && req[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_ptr_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    rr_ptr_next   = rr_ptr;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (!fifo_full && sel_vld) begin
          owner_next = sel_idx;
          if (BURST == 1) begin
            rr_ptr_next = next_idx(sel_idx);
          end else begin
            state_next    = HOLD;
            beat_cnt_next = CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (!req[owner]) begin
          // Owner gave up early; IDLE can serve someone else on the very next cycle.
          state_next  = IDLE;
          rr_ptr_next = next_idx(owner);
        end else if (!fifo_full) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next  = IDLE;
            rr_ptr_next = next_idx(owner);
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: combinational grant so the FIFO captures data on the same edge.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (state)
        IDLE:    if (!fifo_full && sel_vld) gnt[sel_idx] = 1'b1;
        HOLD:    gnt[owner] = req[owner] & ~fifo_full;
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_data_in = fifo_data_in | req_data[i*DATA_W +: DATA_W];
    end
  end

  assign fifo_wr_en = |gnt;
  assign busy       = (state == HOLD);

`ifdef ARB_STALL_CNT_EN
  // Cycles where someone wanted to write but the FIFO was full; saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|req) && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, BURST=4).
// Expected writes are queued as {gnt, data} when stimulus is driven and popped on each FIFO write.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int BURST   = 4;
  localparam int EW      = NUM_REQ + DATA_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      busy;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]               stall_cnt;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .busy         (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset;
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Driver tasks
  task automatic set_data(input int i, input logic [DATA_W-1:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fifo_full = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    checks++;
    if (fifo_data_in !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", fifo_data_in); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef ARB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt: got %b want 0001", gnt); end
    checks++;
    if (fifo_data_in !== 8'hA0) begin errors++; $display("FAIL first_data: got %h want a0", fifo_data_in); end
    apply_reset();
  endtask

  task automatic test_single_requester;
    logic [EW-1:0] e;
    apply_reset();
    req = 4'b0010;
    set_data(1, 8'h0A);
    for (int k = 0; k < 6; k++) exp_q.push_back({4'b0010, 8'h0A});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_no_bubble c%0d: wr_en %b want 1", k, fifo_wr_en); end
      if (fifo_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb: unexpected write %b/%h", gnt, fifo_data_in); end
        else begin
          e = exp_q.pop_front();
          if ({gnt, fifo_data_in} !== e) begin errors++; $display("FAIL single_sb c%0d: got %b/%h want %b/%h", k, gnt, fifo_data_in, e[EW-1:DATA_W], e[DATA_W-1:0]); end
        end
      end
      next_cycle();
    end
    req = '0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: %0d writes missing, want 0", exp_q.size()); end
  endtask

  task automatic test_round_robin;
    logic [EW-1:0] e;
    int idx;
    logic exp_busy;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'h10 + 8'(i));
    for (int k = 0; k < 17; k++) begin
      idx = (k / BURST) % NUM_REQ;
      exp_q.push_back({4'(1 << idx), 8'h10 + 8'(idx)});
    end
    for (int k = 0; k < 17; k++) begin
      exp_busy = ((k % BURST) != 0);
      @(negedge clk);
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL rr_busy c%0d: got %b want %b", k, busy, exp_busy); end
      checks++;
      if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en c%0d: got %b want 1", k, fifo_wr_en); end
      else if (exp_q.size() == 0) begin errors++; $display("FAIL rr_sb: unexpected write %b/%h", gnt, fifo_data_in); end
      else begin
        e = exp_q.pop_front();
        if ({gnt, fifo_data_in} !== e) begin errors++; $display("FAIL rr_sb c%0d: got %b/%h want %b/%h", k, gnt, fifo_data_in, e[EW-1:DATA_W], e[DATA_W-1:0]); end
      end
      next_cycle();
    end
    req = '0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing: %0d writes missing, want 0", exp_q.size()); end
  endtask

  task automatic test_full_stall;
    logic [EW-1:0] e;
    logic [3:0] g_tab [8];
    logic       f_tab [8];
    g_tab = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    f_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply_reset();
    req = 4'b0011;
    set_data(0, 8'h40);
    set_data(1, 8'h41);
    for (int k = 0; k < 8; k++) begin
      fifo_full = f_tab[k];
      if (g_tab[k] != 4'b0000) exp_q.push_back({g_tab[k], (g_tab[k] == 4'b0001) ? 8'h40 : 8'h41});
      @(negedge clk);
      checks++;
      if (gnt !== g_tab[k]) begin errors++; $display("FAIL stall_gnt c%0d: got %b want %b", k, gnt, g_tab[k]); end
      checks++;
      if (fifo_full && fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_write_while_full c%0d: wr_en %b want 0", k, fifo_wr_en); end
      if (fifo_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_sb: unexpected write %b/%h", gnt, fifo_data_in); end
        else begin
          e = exp_q.pop_front();
          if ({gnt, fifo_data_in} !== e) begin errors++; $display("FAIL stall_sb c%0d: got %b/%h want %b/%h", k, gnt, fifo_data_in, e[EW-1:DATA_W], e[DATA_W-1:0]); end
        end
      end
      next_cycle();
    end
    req = '0;
    fifo_full = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing: %0d writes missing, want 0", exp_q.size()); end
  endtask

  task automatic test_early_drop;
    logic [3:0] g_tab [4];
    logic [3:0] r_tab [4];
    g_tab = '{4'b0001, 4'b0001, 4'b0000, 4'b0100};
    r_tab = '{4'b0101, 4'b0101, 4'b0100, 4'b0100};
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'h50 + 8'(i));
    for (int k = 0; k < 4; k++) begin
      req = r_tab[k];
      @(negedge clk);
      checks++;
      if (gnt !== g_tab[k]) begin errors++; $display("FAIL drop_gnt c%0d: got %b want %b", k, gnt, g_tab[k]); end
      if (k == 3) begin
        checks++;
        if (fifo_data_in !== 8'h52) begin errors++; $display("FAIL drop_data: got %h want 52", fifo_data_in); end
      end
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_random_full;
    logic [EW-1:0] e;
    logic [DATA_W-1:0] d;
    apply_reset();
    req = 4'b0100;
    d = 8'($urandom_range(0, 255));
    set_data(2, d);
    for (int k = 0; k < 24; k++) begin
      fifo_full = 1'($urandom_range(0, 1));
      if (!fifo_full) exp_q.push_back({4'b0100, d});
      @(negedge clk);
      checks++;
      if (fifo_full && fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rand_write_while_full c%0d: wr_en %b want 0", k, fifo_wr_en); end
      if (fifo_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_sb: unexpected write %b/%h", gnt, fifo_data_in); end
        else begin
          e = exp_q.pop_front();
          if ({gnt, fifo_data_in} !== e) begin errors++; $display("FAIL rand_sb c%0d: got %b/%h want %b/%h", k, gnt, fifo_data_in, e[EW-1:DATA_W], e[DATA_W-1:0]); end
        end
      end
      next_cycle();
      if (!fifo_full) begin
        d = 8'($urandom_range(0, 255));
        set_data(2, d);
      end
    end
    req = '0;
    fifo_full = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing: %0d writes missing, want 0", exp_q.size()); end
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall_cnt;
    apply_reset();
    req = 4'b0001;
    set_data(0, 8'h60);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stallcnt_write c%0d: wr_en %b want 0", k, fifo_wr_en); end
      next_cycle();
    end
    req = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt_value: got %0d want 5", stall_cnt); end
    next_cycle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_random_full();
`ifdef ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
